// File: rtl/sys_bus_pkg.sv
// sys_bus_pkg: shared types and constants for the sys_bus arbiter slice.
package sys_bus_pkg;
    localparam int BUS_AW = 64;
    localparam int BUS_DW = 64;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_IF_XFER  = 2'd1,
        ARB_MEM_XFER = 2'd2,
        ARB_DONE     = 2'd3
    } arb_state_e;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    localparam logic [2:0] CTRL_NONE = 3'b000;
    localparam logic [2:0] CTRL_8    = 3'b001;
    localparam logic [2:0] CTRL_32   = 3'b010;
    localparam logic [2:0] CTRL_64   = 3'b011;
    localparam logic [2:0] CTRL_16   = 3'b100;
    localparam logic [2:0] CTRL_FETCH32 = CTRL_32;
endpackage

// File: rtl/sys_bus_arbiter_if.sv
// sys_bus_arbiter_if: fetch port, load/store port and sys_bus signals of the arbiter.
interface sys_bus_arbiter_if;
    import sys_bus_pkg::*;
    logic              if_req;
    logic [BUS_AW-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              mem_req;
    logic [BUS_AW-1:0] mem_addr;
    logic [2:0]        mem_rd_ctrl;
    logic [2:0]        mem_wr_ctrl;
    logic [BUS_DW-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [BUS_DW-1:0] mem_rdata;
    logic              mem_busy;
    logic              xfer_err;
    logic [2:0]        bus_rd_ctrl;
    logic [2:0]        bus_wr_ctrl;
    logic [BUS_AW-1:0] bus_addr;
    logic [BUS_DW-1:0] bus_din;
    logic [BUS_DW-1:0] bus_dout;
    logic              bus_ready;

    modport slave (
        input  if_req, if_addr, mem_req, mem_addr, mem_rd_ctrl, mem_wr_ctrl, mem_wdata,
               bus_dout, bus_ready,
        output if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata, mem_busy,
               xfer_err, bus_rd_ctrl, bus_wr_ctrl, bus_addr, bus_din
    );
    modport master (
        output if_req, if_addr, mem_req, mem_addr, mem_rd_ctrl, mem_wr_ctrl, mem_wdata,
               bus_dout, bus_ready,
        input  if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata, mem_busy,
               xfer_err, bus_rd_ctrl, bus_wr_ctrl, bus_addr, bus_din
    );
endinterface

// File: rtl/bus_xfer_timer.sv
// bus_xfer_timer: 8-bit saturating transfer timeout counter with clear, enable and expired flag.
module bus_xfer_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst)
            r_cnt <= 8'd0;
        else if (i_clr)
            r_cnt <= 8'd0;
        else if (i_en && r_cnt != 8'(LIMIT))
            r_cnt <= r_cnt + 8'd1;
    end

    // Flags the cycle whose stall would bring the count to LIMIT, so LIMIT waiting cycles elapse.
    assign o_expired = r_cnt >= 8'(LIMIT - 1);
endmodule

// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter: registered grant FSM sharing sys_bus between IF fetch and MEM load/store.
// Optional ARB_STARVE_GUARD_EN forces an IF grant after STARVE_MAX consecutive MEM grants.
module sys_bus_arbiter
    import sys_bus_pkg::*;
#(
    parameter logic [2:0] IF_RD_CTRL  = CTRL_FETCH32,
    parameter int         TIMEOUT_CYC = 255,
    parameter int         STARVE_MAX  = 4
) (
    input logic              clk,
    input logic              rst,
    sys_bus_arbiter_if.slave io_bus
);
    localparam logic [1:0] S_IDLE     = ARB_IDLE;
    localparam logic [1:0] S_IF_XFER  = ARB_IF_XFER;
    localparam logic [1:0] S_MEM_XFER = ARB_MEM_XFER;
    localparam logic [1:0] S_DONE     = ARB_DONE;

    logic [1:0]        r_state;
    logic              r_owner;
    logic              r_err;
    logic [BUS_AW-1:0] r_addr;
    logic [2:0]        r_rd;
    logic [2:0]        r_wr;
    logic [BUS_DW-1:0] r_wdata;
    logic [BUS_DW-1:0] r_mem_rdata;
    logic [31:0]       r_if_rdata;

    logic w_idle, w_xfer, w_done, w_force_if, w_gnt_if, w_gnt_mem, w_expired, w_finish, w_store;

    assign w_idle    = r_state == S_IDLE;
    assign w_xfer    = r_state == S_IF_XFER || r_state == S_MEM_XFER;
    assign w_done    = r_state == S_DONE;
    assign w_store   = io_bus.mem_wr_ctrl != CTRL_NONE;
    assign w_gnt_mem = w_idle && io_bus.mem_req && !w_force_if;
    assign w_gnt_if  = w_idle && io_bus.if_req && (!io_bus.mem_req || w_force_if);
    assign w_finish  = w_xfer && (io_bus.bus_ready || w_expired);

`ifdef ARB_STARVE_GUARD_EN
    logic [2:0] r_starve;

    assign w_force_if = io_bus.if_req && r_starve >= 3'(STARVE_MAX);

    always_ff @(posedge clk) begin
        if (!rst)
            r_starve <= 3'd0;
        else if (w_gnt_if)
            r_starve <= 3'd0;
        else if (w_gnt_mem && io_bus.if_req && r_starve != 3'd7)
            r_starve <= r_starve + 3'd1;
    end
`else
    assign w_force_if = 1'b0;
`endif

    bus_xfer_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_idle),
        .i_en      (w_xfer && !io_bus.bus_ready),
        .o_expired (w_expired)
    );

    // Bus controls are resolved at grant time so XFER drives registers only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_owner     <= OWN_IF;
            r_err       <= 1'b0;
            r_addr      <= '0;
            r_rd        <= CTRL_NONE;
            r_wr        <= CTRL_NONE;
            r_wdata     <= '0;
            r_mem_rdata <= '0;
            r_if_rdata  <= '0;
        end else if (w_gnt_mem) begin
            r_state <= S_MEM_XFER;
            r_owner <= OWN_MEM;
            r_addr  <= io_bus.mem_addr;
            r_wr    <= io_bus.mem_wr_ctrl;
            r_rd    <= w_store ? CTRL_NONE : io_bus.mem_rd_ctrl;
            r_wdata <= w_store ? io_bus.mem_wdata : '0;
        end else if (w_gnt_if) begin
            r_state <= S_IF_XFER;
            r_owner <= OWN_IF;
            r_addr  <= io_bus.if_addr;
            r_rd    <= IF_RD_CTRL;
            r_wr    <= CTRL_NONE;
            r_wdata <= '0;
        end else if (w_finish) begin
            r_state <= S_DONE;
            r_err   <= !io_bus.bus_ready;
            if (r_owner == OWN_MEM)
                r_mem_rdata <= io_bus.bus_ready ? io_bus.bus_dout : '0;
            else
                r_if_rdata <= io_bus.bus_ready ? io_bus.bus_dout[31:0] : 32'd0;
        end else if (w_done) begin
            r_state <= S_IDLE;
            r_err   <= 1'b0;
        end
    end

    assign io_bus.if_gnt      = w_gnt_if;
    assign io_bus.mem_gnt     = w_gnt_mem;
    assign io_bus.if_rvalid   = w_done && r_owner == OWN_IF;
    assign io_bus.mem_rvalid  = w_done && r_owner == OWN_MEM;
    assign io_bus.xfer_err    = w_done && r_err;
    assign io_bus.if_rdata    = r_if_rdata;
    assign io_bus.mem_rdata   = r_mem_rdata;
    assign io_bus.mem_busy    = io_bus.mem_req || r_state == S_MEM_XFER || (w_done && r_owner == OWN_MEM);
    assign io_bus.bus_rd_ctrl = w_xfer ? r_rd : CTRL_NONE;
    assign io_bus.bus_wr_ctrl = w_xfer ? r_wr : CTRL_NONE;
    assign io_bus.bus_addr    = w_xfer ? r_addr : '0;
    assign io_bus.bus_din     = w_xfer ? r_wdata : '0;
endmodule

// File: tb/tb_sys_bus_arbiter.sv
// tb_sys_bus_arbiter: table-driven cycle vectors plus reset and arbitration-order sequences.
module tb_sys_bus_arbiter;
    localparam logic [63:0] A_IF  = 64'h1000;
    localparam logic [63:0] A_MEM = 64'h2000;
    localparam logic [63:0] WD    = 64'hDEADBEEF;
    localparam logic [63:0] D1    = 64'h1122334455667788;
    localparam logic [31:0] I2    = 32'h00100093;
    localparam int          NV    = 23;

    typedef struct {
        logic        ifr;
        logic        mr;
        logic [2:0]  mrd;
        logic [2:0]  mwr;
        logic        rdy;
        logic [63:0] dout;
        logic [5:0]  flags;
        logic [2:0]  brd;
        logic [2:0]  bwr;
        logic [63:0] baddr;
        logic [63:0] bdin;
        logic [31:0] ird;
        logic [63:0] mrdd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    vec_t v [NV];

    always #5 clk = ~clk;

    sys_bus_arbiter_if bus_if ();

    sys_bus_arbiter #(.IF_RD_CTRL(3'b010), .TIMEOUT_CYC(4), .STARVE_MAX(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus_if)
    );

    function automatic logic [235:0] snap();
        return {bus_if.if_gnt, bus_if.mem_gnt, bus_if.if_rvalid, bus_if.mem_rvalid,
                bus_if.mem_busy, bus_if.xfer_err, bus_if.bus_rd_ctrl, bus_if.bus_wr_ctrl,
                bus_if.bus_addr, bus_if.bus_din, bus_if.if_rdata, bus_if.mem_rdata};
    endfunction

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic ifr, input logic mr, input logic [2:0] mrd,
                         input logic [2:0] mwr, input logic rdy, input logic [63:0] dout);
        bus_if.if_req      = ifr;
        bus_if.mem_req     = mr;
        bus_if.mem_rd_ctrl = mrd;
        bus_if.mem_wr_ctrl = mwr;
        bus_if.bus_ready   = rdy;
        bus_if.bus_dout    = dout;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string order;
        int    ngnt;
        logic  rv_seen;
        bus_if.if_addr   = A_IF;
        bus_if.mem_addr  = A_MEM;
        bus_if.mem_wdata = WD;
        drive(0, 0, 0, 0, 0, 0);

        v[0]  = '{1, 0, 0, 0, 0, 0,       6'b100000, 0, 0, 0,     0,  0,      0};
        v[1]  = '{0, 0, 0, 0, 1, 64'h13,  6'b000000, 2, 0, A_IF,  0,  0,      0};
        v[2]  = '{0, 0, 0, 0, 0, 0,       6'b001000, 0, 0, 0,     0,  32'h13, 0};
        v[3]  = '{0, 0, 0, 0, 0, 0,       6'b000000, 0, 0, 0,     0,  32'h13, 0};
        v[4]  = '{1, 1, 3, 0, 0, 0,       6'b010010, 0, 0, 0,     0,  32'h13, 0};
        v[5]  = '{1, 0, 0, 0, 1, D1,      6'b000010, 3, 0, A_MEM, 0,  32'h13, 0};
        v[6]  = '{1, 0, 0, 0, 0, 0,       6'b000110, 0, 0, 0,     0,  32'h13, D1};
        v[7]  = '{1, 0, 0, 0, 0, 0,       6'b100000, 0, 0, 0,     0,  32'h13, D1};
        v[8]  = '{0, 0, 0, 0, 1, 64'hAAAABBBB00100093, 6'b000000, 2, 0, A_IF, 0, 32'h13, D1};
        v[9]  = '{0, 0, 0, 0, 0, 0,       6'b001000, 0, 0, 0,     0,  I2,     D1};
        v[10] = '{0, 1, 1, 3, 0, 0,       6'b010010, 0, 0, 0,     0,  I2,     D1};
        v[11] = '{0, 0, 0, 0, 0, 0,       6'b000010, 0, 3, A_MEM, WD, I2,     D1};
        v[12] = '{0, 0, 0, 0, 0, 0,       6'b000010, 0, 3, A_MEM, WD, I2,     D1};
        v[13] = '{0, 0, 0, 0, 1, 64'h55,  6'b000010, 0, 3, A_MEM, WD, I2,     D1};
        v[14] = '{0, 0, 0, 0, 0, 0,       6'b000110, 0, 0, 0,     0,  I2,     64'h55};
        v[15] = '{0, 0, 0, 0, 0, 0,       6'b000000, 0, 0, 0,     0,  I2,     64'h55};
        v[16] = '{1, 0, 0, 0, 0, 0,       6'b100000, 0, 0, 0,     0,  I2,     64'h55};
        for (int i = 17; i < 21; i++)
            v[i] = '{0, 0, 0, 0, 0, 0,    6'b000000, 2, 0, A_IF,  0,  I2,     64'h55};
        v[21] = '{0, 0, 0, 0, 0, 0,       6'b001001, 0, 0, 0,     0,  0,      64'h55};
        v[22] = '{0, 0, 0, 0, 0, 0,       6'b000000, 0, 0, 0,     0,  0,      64'h55};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {20'd0, snap()}, 256'd0);
        next_cycle();
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(v[i].ifr, v[i].mr, v[i].mrd, v[i].mwr, v[i].rdy, v[i].dout);
            @(negedge clk);
            chk($sformatf("vec%0d", i), {20'd0, snap()},
                {20'd0, v[i].flags, v[i].brd, v[i].bwr, v[i].baddr, v[i].bdin, v[i].ird, v[i].mrdd});
            next_cycle();
        end

        drive(0, 1, 3, 0, 0, 0);
        @(negedge clk);
        chk("rst_mid_gnt", {255'd0, bus_if.mem_gnt}, 256'd1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_xfer_rd", {253'd0, bus_if.bus_rd_ctrl}, 256'd3);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_clear", {20'd0, snap()}, 256'd0);
        rv_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rv_seen |= bus_if.mem_rvalid;
        end
        chk("rst_mid_no_rvalid", {255'd0, rv_seen}, 256'd0);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_after_if_gnt", {255'd0, bus_if.if_gnt}, 256'd1);
        next_cycle();
        drive(0, 0, 0, 0, 1, 64'h13);
        rv_seen = 1'b0;
        for (int i = 0; i < 5 && !rv_seen; i++) begin
            @(negedge clk);
            if (bus_if.if_rvalid) begin
                rv_seen = 1'b1;
                chk("rst_after_if_rdata", {224'd0, bus_if.if_rdata}, 256'h13);
            end
            next_cycle();
        end
        chk("rst_after_if_rvalid", {255'd0, rv_seen}, 256'd1);

        drive(0, 0, 0, 0, 0, 0);
        repeat (2) next_cycle();
        drive(1, 1, 3, 0, 1, 0);
        order = "";
        ngnt = 0;
        for (int i = 0; i < 40 && ngnt < 6; i++) begin
            @(negedge clk);
            if (bus_if.mem_gnt) begin
                order = {order, "M"};
                ngnt++;
            end else if (bus_if.if_gnt) begin
                order = {order, "I"};
                ngnt++;
            end
            next_cycle();
        end
        total++;
`ifdef ARB_STARVE_GUARD_EN
        if (order != "MMMMIM") begin
            bad++;
            $display("FAIL grant_order got=%s want=MMMMIM", order);
        end
`else
        if (order != "MMMMMM") begin
            bad++;
            $display("FAIL grant_order got=%s want=MMMMMM", order);
        end
`endif
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
